// File: rtl/bit4_adder_arbiter.sv
// Two-requester round-robin front end for one shared 4-bit adder, with a registered, tagged response.
// Optional grant counters are compiled in with ARB_STATS_EN.

module bit4_adder (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [4:0] s
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign s[4] = c[4];
endmodule

module bit4_adder_arbiter
`ifdef ARB_STATS_EN
  #(parameter int CNT_W = 8)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [3:0] a_x,
  input  logic [3:0] a_y,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [3:0] b_x,
  input  logic [3:0] b_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_sum,
  output logic       rsp_src
`ifdef ARB_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] a_grant_cnt,
  output logic [CNT_W-1:0] b_grant_cnt
`endif
);
  logic       prio;
  logic       out_free;
  logic       gnt_a, gnt_b;
  logic [3:0] sel_x, sel_y;
  logic [4:0] sum;

  // rst_n gates the grants so neither ready can rise while reset is held.
  always_comb begin
    out_free = !rsp_valid || rsp_ready;
    gnt_a    = rst_n && out_free && a_valid && (!b_valid || !prio);
    gnt_b    = rst_n && out_free && b_valid && (!a_valid ||  prio);
    sel_x    = gnt_b ? b_x : a_x;
    sel_y    = gnt_b ? b_y : a_y;
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  bit4_adder u_add (.x(sel_x), .y(sel_y), .cin(1'b0), .s(sum));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= 5'd0;
      rsp_src   <= 1'b0;
      prio      <= 1'b0;
    end else if (gnt_a || gnt_b) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= sum;
      rsp_src   <= gnt_b;
      prio      <= gnt_a;  // loser of this grant gets priority next time
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
    end else if (stats_clr) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
    end else begin
      if (gnt_a && !(&a_grant_cnt)) a_grant_cnt <= a_grant_cnt + 1'b1;
      if (gnt_b && !(&b_grant_cnt)) b_grant_cnt <= b_grant_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_bit4_adder_arbiter.sv
// Bench for bit4_adder_arbiter: directed vector table, reset corners, and a random run against a behavioural model.
// Counter checks are compiled in with ARB_STATS_EN.

module tb_bit4_adder_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, rsp_ready;
  logic       a_ready, b_ready, rsp_valid, rsp_src;
  logic [3:0] a_x, a_y, b_x, b_y;
  logic [4:0] rsp_sum;
`ifdef ARB_STATS_EN
  logic       stats_clr;
  logic [7:0] a_grant_cnt, b_grant_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bit4_adder_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_src(rsp_src)
`ifdef ARB_STATS_EN
    , .stats_clr(stats_clr), .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt)
`endif
  );

  typedef struct {
    logic av; logic [3:0] ax; logic [3:0] ay;
    logic bv; logic [3:0] bx; logic [3:0] by;
    logic rr;
    logic ea; logic eb; logic ev; logic [4:0] es; logic esrc;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ax, input logic [3:0] ay,
                       input logic bv, input logic [3:0] bx, input logic [3:0] by,
                       input logic rr);
    a_valid = av; a_x = ax; a_y = ay;
    b_valid = bv; b_x = bx; b_y = by;
    rsp_ready = rr;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Behavioural model state
  logic       m_vld, m_src, m_prio;
  logic [4:0] m_sum;
  int         m_ca, m_cb;

  initial begin
    // Directed sequence: {A inputs, B inputs, rsp_ready, exp a_ready, b_ready, rsp_valid, sum, src}
    tbl[0]  = '{1, 4'h9, 4'h8, 0, 4'h0, 4'h0, 1,  1, 0, 1, 5'h11, 0};
    tbl[1]  = '{1, 4'h3, 4'h4, 1, 4'hF, 4'hF, 1,  0, 1, 1, 5'h1E, 1};
    tbl[2]  = '{1, 4'h3, 4'h4, 1, 4'hF, 4'hF, 1,  1, 0, 1, 5'h07, 0};
    tbl[3]  = '{1, 4'h3, 4'h4, 1, 4'hF, 4'hF, 1,  0, 1, 1, 5'h1E, 1};
    tbl[4]  = '{1, 4'h3, 4'h4, 1, 4'hF, 4'hF, 0,  0, 0, 1, 5'h1E, 1};
    tbl[5]  = '{1, 4'h3, 4'h4, 1, 4'hF, 4'hF, 0,  0, 0, 1, 5'h1E, 1};
    tbl[6]  = '{1, 4'h3, 4'h4, 1, 4'hF, 4'hF, 0,  0, 0, 1, 5'h1E, 1};
    tbl[7]  = '{1, 4'h3, 4'h4, 1, 4'hF, 4'hF, 1,  1, 0, 1, 5'h07, 0};
    tbl[8]  = '{0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1,  0, 0, 0, 5'h07, 0};
    tbl[9]  = '{1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1,  1, 0, 1, 5'h00, 0};
    tbl[10] = '{0, 4'h0, 4'h0, 1, 4'h0, 4'h1, 0,  0, 0, 1, 5'h00, 0};
    tbl[11] = '{0, 4'h0, 4'h0, 1, 4'h0, 4'h1, 1,  0, 1, 1, 5'h01, 1};

    // Reset state, readies held low during reset even with a valid presented
    drive(0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_src", rsp_src, 0);
    a_valid = 1'b1; b_valid = 1'b1; rsp_ready = 1'b1; #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_rsp_sum", rsp_sum, 0);
      chk("idle_ready", {a_ready, b_ready}, 0);
    end

    // Directed table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].av, tbl[i].ax, tbl[i].ay, tbl[i].bv, tbl[i].bx, tbl[i].by, tbl[i].rr);
      #1;
      chk($sformatf("vec%0d_a_ready", i), a_ready, tbl[i].ea);
      chk($sformatf("vec%0d_b_ready", i), b_ready, tbl[i].eb);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, tbl[i].ev);
      chk($sformatf("vec%0d_rsp_sum", i), rsp_sum, tbl[i].es);
      chk($sformatf("vec%0d_rsp_src", i), rsp_src, tbl[i].esrc);
    end

    // Reset mid-transaction: A granted last so prio points at B; reset must restore A
    drive(1, 4'h5, 4'h5, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("pre_rst_sum", rsp_sum, 5'h0A);
    drive(1, 4'h2, 4'h6, 1, 4'h1, 4'h1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_ready", {a_ready, b_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("postrst_a_ready", a_ready, 1);
    chk("postrst_b_ready", b_ready, 0);
    @(posedge clk); #1;
    chk("postrst_sum", rsp_sum, 5'h08);
    chk("postrst_src", rsp_src, 0);

`ifdef ARB_STATS_EN
    // Saturation and clear-beats-increment
    do_reset();
    drive(1, 4'h1, 4'h1, 0, 0, 0, 1);
    repeat (300) @(posedge clk);
    #1;
    chk("sat_a_cnt", a_grant_cnt, 8'hFF);
    chk("sat_b_cnt", b_grant_cnt, 8'h00);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    chk("clr_a_cnt", a_grant_cnt, 8'h00);
    @(posedge clk); #1;
    chk("after_clr_a_cnt", a_grant_cnt, 8'h01);
`endif

    // Random run against the model
    do_reset();
    m_vld = 0; m_sum = 0; m_src = 0; m_prio = 0; m_ca = 0; m_cb = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic free, ga, gb, clr;
      drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
            $urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
            $urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 30) == 0);
`ifdef ARB_STATS_EN
      stats_clr = clr;
`endif
      #1;
      free = !m_vld || rsp_ready;
      ga = free && a_valid && (!b_valid || m_prio == 0);
      gb = free && b_valid && (!a_valid || m_prio == 1);
      chk("rnd_a_ready", a_ready, ga);
      chk("rnd_b_ready", b_ready, gb);
      if (ga || gb) begin
        m_vld  = 1;
        m_sum  = gb ? b_x + b_y : a_x + a_y;
        m_src  = gb;
        m_prio = !gb;
      end else if (rsp_ready) begin
        m_vld = 0;
      end
      if (clr) begin
        m_ca = 0; m_cb = 0;
      end else begin
        if (ga && m_ca < 255) m_ca++;
        if (gb && m_cb < 255) m_cb++;
      end
      @(posedge clk); #1;
      chk("rnd_rsp_valid", rsp_valid, m_vld);
      chk("rnd_rsp_sum", rsp_sum, m_sum);
      chk("rnd_rsp_src", rsp_src, m_src);
`ifdef ARB_STATS_EN
      chk("rnd_a_cnt", a_grant_cnt, m_ca);
      chk("rnd_b_cnt", b_grant_cnt, m_cb);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bit4_adder_arbiter.md
Name: bit4_adder_arbiter

Overview:
- Shares a single bit4_adder instance between two requesters, A and B.
- Each requester has a valid/ready operand handshake. Requests are granted round-robin.
- One 5-bit result is registered per granted request, with a source tag, on a shared response port that supports backpressure.
- Sits between operand producers and the downstream consumer of sums, so datapath blocks do not each instantiate their own adder.

Parameters:
CNT_W, 8, width of each grant counter (used only when ARB_STATS_EN is defined)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
a_valid  input  1  requester A has operands
a_ready  output  1  requester A operands accepted this cycle
a_x  input  4  requester A operand x
a_y  input  4  requester A operand y
b_valid  input  1  requester B has operands
b_ready  output  1  requester B operands accepted this cycle
b_x  input  4  requester B operand x
b_y  input  4  requester B operand y
rsp_valid  output  1  response register holds a result
rsp_ready  input  1  consumer takes the result this cycle
rsp_sum  output  5  x+y; bit 4 is the carry out
rsp_src  output  1  requester of the result: 0=A, 1=B

Behaviour:
- Clock/reset: one clock domain (clk). rst_n is asynchronous, active-low. Assertion takes effect immediately; release is synchronous to clk.
- Reset values:
  - rsp_valid=0, rsp_sum=5'd0, rsp_src=0.
  - Priority pointer prio=A (0).
  - a_ready=b_ready=0 while rst_n=0.
- Slot free: out_free = !rsp_valid || rsp_ready. Combinational; a result draining this cycle frees the slot for a same-cycle grant.
- Arbitration (combinational, evaluated only when out_free=1):
  - Only a_valid=1: grant A.
  - Only b_valid=1: grant B.
  - Both valid: grant the requester indicated by prio.
  - Neither valid: no grant.
- Ready outputs:
  - a_ready = out_free && grant==A.
  - b_ready = out_free && grant==B.
  - Never both 1 in the same cycle.
  - Ready may depend on the requester's own valid.
- Transfer: a requester transfers when valid && ready. Operands must be stable while valid && !ready. The arbiter does not hold operands.
- Datapath:
  - Operand mux selects the granted pair into the single bit4_adder (carry-in fixed 0).
  - On a grant at edge N: rsp_sum <= adder S[4:0], rsp_src <= granted id, rsp_valid <= 1, all visible after edge N.
  - Latency 1 cycle. Throughput 1 result/cycle when rsp_ready is held high.
- Response handshake:
  - Result is consumed when rsp_valid && rsp_ready.
  - If consumed with no new grant: rsp_valid <= 0; rsp_sum and rsp_src hold their last values.
  - While rsp_valid && !rsp_ready: rsp_sum and rsp_src are held stable, no grants, both readies 0.
- Priority update: after every grant, prio <= the requester not granted. A lone requester therefore yields to the other at the next contention. prio is unchanged when there is no grant.
- Boundary conditions:
  - Max sum 4'hF+4'hF=5'h1E.
  - Zero operands give 5'h00 with rsp_valid=1 (valid results are not suppressed).
  - Reset mid-transaction discards any held result with no response. Requesters must re-present operands.
  - A valid dropped without ready is legal and is simply not served.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds port stats_clr (input, 1, synchronous clear).
  - Adds a_grant_cnt and b_grant_cnt (outputs, CNT_W each).
  - Each counter increments by 1 on its requester's transfer and saturates at all-ones.
  - stats_clr=1 zeroes both counters on the next edge and takes priority over a same-cycle increment.
  - Both counters reset to 0 on rst_n.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle, rst_n released, no valids -> rsp_valid=0, rsp_sum=0, a_ready=b_ready=0 for 5 cycles.
- A alone, a_x=4'h9 a_y=4'h8, rsp_ready=1 -> a_ready=1 same cycle; next cycle rsp_valid=1, rsp_sum=5'h11, rsp_src=0.
- Both valid continuously, A 3+4, B F+F, rsp_ready=1 -> grants A,B,A,B...; rsp_sum alternates 5'h07 (src0) / 5'h1E (src1), one per cycle.
- Backpressure: result held, rsp_ready=0 for 3 cycles with both valid -> rsp_sum/src stable, a_ready=b_ready=0; rsp_ready=1 -> same-cycle grant to prio, new result next cycle.
- Reset mid-op: rst_n low while rsp_valid=1 -> rsp_valid=0 immediately (asynchronous); after release, first contention grants A.
- ARB_STATS_EN: 300 A grants with CNT_W=8 -> a_grant_cnt=8'hFF; stats_clr pulse together with a grant -> counter=0.
